// File: rtl/aes_round_scheduler_if.sv
// Request/response handshake bundle between the SPI-side driver (master)
// and the AES round scheduler (slave).
interface aes_round_scheduler_if;
    logic         enc_valid;
    logic         enc_ready;
    logic [127:0] enc_data;
    logic         dec_valid;
    logic         dec_ready;
    logic [127:0] dec_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_is_dec;

    modport master (
        output enc_valid, enc_data, dec_valid, dec_data, out_ready,
        input  enc_ready, dec_ready, out_valid, out_data, out_is_dec
    );

    modport slave (
        input  enc_valid, enc_data, dec_valid, dec_data, out_ready,
        output enc_ready, dec_ready, out_valid, out_data, out_is_dec
    );
endinterface

// File: rtl/aes_round_scheduler.sv
// Iterative AES round sequencer: arbitrates encrypt/decrypt requests and steps
// one shared combinational round engine through rounds 0..Nr.
module aes_round_scheduler #(
    parameter int KEY_BUS_W = 1920
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           key_len,
    input  logic [KEY_BUS_W-1:0] expanded_key,
    aes_round_scheduler_if.slave bus,
    output logic [127:0]         eng_state,
    output logic [127:0]         eng_key,
    output logic                 eng_inv,
    output logic                 eng_first,
    output logic                 eng_final,
    input  logic [127:0]         eng_result,
    output logic                 busy,
    output logic [3:0]           round_idx
);
    localparam int NUM_KEYS = KEY_BUS_W / 128;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   nr_q, nr_d;
    logic         inv_q, inv_d;
    logic         last_grant_q, last_grant_d;   // 1 = decrypt channel
    logic [127:0] data_q, data_d;
    logic         out_valid_q, out_valid_d;

    logic         key_legal;
    logic [3:0]   nr_new;
    logic         grant_enc, grant_dec;
    logic         enc_ready_c, dec_ready_c;
    logic [3:0]   key_idx;

    assign key_legal = (key_len == 8'd16) || (key_len == 8'd24) || (key_len == 8'd32);
    assign nr_new    = key_len[5:2] + 4'd6;
    // Ties go to whichever channel was not served last.
    assign grant_dec = bus.dec_valid && (!bus.enc_valid || !last_grant_q);
    assign grant_enc = bus.enc_valid && !grant_dec;

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        nr_d         = nr_q;
        inv_d        = inv_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        out_valid_d  = out_valid_q;
        enc_ready_c  = 1'b0;
        dec_ready_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_legal) begin
                    enc_ready_c = grant_enc;
                    dec_ready_c = grant_dec;
                    if (grant_enc || grant_dec) begin
                        data_d       = grant_dec ? bus.dec_data : bus.enc_data;
                        round_d      = 4'd0;
                        nr_d         = nr_new;
                        inv_d        = grant_dec;
                        last_grant_d = grant_dec;
                        state_d      = ROUND;
                    end
                end
            end
            ROUND: begin
                data_d = eng_result;
                if (round_q == nr_q) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            round_q      <= 4'd0;
            nr_q         <= 4'd0;
            inv_q        <= 1'b0;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            nr_q         <= nr_d;
            inv_q        <= inv_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Decryption walks the key schedule backwards from round key Nr.
    assign key_idx = inv_q ? (nr_q - round_q) : round_q;

    always_comb begin
        eng_key   = '0;
        eng_inv   = 1'b0;
        eng_first = 1'b0;
        eng_final = 1'b0;
        if (state_q == ROUND) begin
            eng_inv   = inv_q;
            eng_first = (round_q == 4'd0);
            eng_final = (round_q == nr_q);
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_idx == 4'(i))
                    eng_key = expanded_key[KEY_BUS_W-1-128*i -: 128];
            end
        end
    end

    assign eng_state      = data_q;
    assign bus.enc_ready  = enc_ready_c;
    assign bus.dec_ready  = dec_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = (state_q == DONE) ? data_q : '0;
    assign bus.out_is_dec = (state_q == DONE) && inv_q;
    assign busy           = (state_q != IDLE);
    assign round_idx      = round_q;
endmodule
